// File: rtl/wb_master_port.sv
// wb_master_port
// Wishbone B4 pipelined bus initiator. Turns a simple command/response handshake
// into Wishbone cycles: single-beat writes and incrementing-address read bursts with
// pipelined strobes. Honours wb_stall_i and aborts with an error response when no
// beat is accepted and no ack arrives for TIMEOUT cycles.
//
// Ports
//   clk_i, rst_i         clock, asynchronous active-low reset
//   cmd_valid_i/ready_o  command handshake; ready only while idle
//   cmd_we_i             1 = single write, 0 = read burst
//   cmd_adr_i/dat_i/sel_i  start byte address, write data, byte selects
//   cmd_len_i            read beat count (0 behaves as 1, ignored for writes)
//   rsp_valid_o          one-cycle response pulse, no backpressure
//   rsp_dat_o            read data (0 for write and error responses)
//   rsp_last_o           final response of the command
//   rsp_err_o            watchdog abort
//   busy_o               mirrors wb_cyc_o
//   wb_*                 Wishbone B4 pipelined initiator interface
module wb_master_port #(
  parameter int unsigned LEN_W    = 4,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned ADR_STEP = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [31:0]      cmd_adr_i,
  input  logic [31:0]      cmd_dat_i,
  input  logic [3:0]       cmd_sel_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  output logic             rsp_valid_o,
  output logic [31:0]      rsp_dat_o,
  output logic             rsp_last_o,
  output logic             rsp_err_o,
  output logic             busy_o,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  output logic [31:0]      wb_adr_o,
  output logic             wb_we_o,
  output logic [3:0]       wb_sel_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  input  logic             wb_ack_i,
  input  logic             wb_stall_i
);

  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e           state_q, state_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             cyc_q, cyc_d;
  logic             stb_q, stb_d;
  logic [31:0]      adr_q, adr_d;
  logic [31:0]      wdat_q, wdat_d;
  logic             we_q, we_d;
  logic [3:0]       sel_q, sel_d;
  logic [LEN_W-1:0] beats_q, beats_d;
  logic [LEN_W-1:0] issued_q, issued_d;
  logic [LEN_W-1:0] acked_q, acked_d;
  logic [WdW-1:0]   wd_q, wd_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_dat_q, rsp_dat_d;
  logic             rsp_last_q, rsp_last_d;
  logic             rsp_err_q, rsp_err_d;

  logic             accept;
  logic             ack_cnt;
  logic [LEN_W-1:0] issued_inc;
  logic [LEN_W-1:0] acked_inc;

  always_comb begin
    // Beat accepted this edge; an ack may retire the beat being accepted on the same edge.
    accept     = cyc_q && stb_q && !wb_stall_i;
    issued_inc = issued_q + LEN_W'(accept);
    ack_cnt    = cyc_q && wb_ack_i && (acked_q < issued_inc);
    acked_inc  = acked_q + LEN_W'(ack_cnt);
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    adr_d       = adr_q;
    wdat_d      = wdat_q;
    we_d        = we_q;
    sel_d       = sel_q;
    beats_d     = beats_q;
    issued_d    = issued_q;
    acked_d     = acked_q;
    wd_d        = wd_q;
    rsp_valid_d = 1'b0;
    rsp_dat_d   = '0;
    rsp_last_d  = 1'b0;
    rsp_err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i && cmd_ready_q) begin
          state_d     = StActive;
          cmd_ready_d = 1'b0;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
          adr_d       = cmd_adr_i;
          wdat_d      = cmd_dat_i;
          we_d        = cmd_we_i;
          sel_d       = cmd_sel_i;
          if (cmd_we_i || (cmd_len_i == '0)) begin
            beats_d = LEN_W'(1);
          end else begin
            beats_d = cmd_len_i;
          end
          issued_d = '0;
          acked_d  = '0;
          wd_d     = '0;
        end
      end

      StActive: begin
        if (accept) begin
          issued_d = issued_inc;
          if (issued_inc < beats_q) begin
            adr_d = adr_q + 32'(ADR_STEP);
          end else begin
            stb_d = 1'b0;
          end
        end

        if (ack_cnt) begin
          acked_d     = acked_inc;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = we_q ? 32'h0 : wb_dat_i;
          rsp_last_d  = (acked_inc == beats_q);
        end

        if (accept || ack_cnt) begin
          wd_d = '0;
        end else begin
          wd_d = wd_q + WdW'(1);
        end

        if (ack_cnt && (acked_inc == beats_q)) begin
          state_d     = StIdle;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          cmd_ready_d = 1'b1;
        end else if (!accept && !ack_cnt && (wd_q == WdW'(TIMEOUT - 1))) begin
          // Watchdog expiry: remaining beats are dropped, single error response.
          state_d     = StIdle;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_last_d  = 1'b1;
          rsp_dat_d   = '0;
        end
      end

      default: begin
        state_d     = StIdle;
        cmd_ready_d = 1'b1;
        cyc_d       = 1'b0;
        stb_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b1;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      adr_q       <= '0;
      wdat_q      <= '0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      beats_q     <= '0;
      issued_q    <= '0;
      acked_q     <= '0;
      wd_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      adr_q       <= adr_d;
      wdat_q      <= wdat_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      beats_q     <= beats_d;
      issued_q    <= issued_d;
      acked_q     <= acked_d;
      wd_q        <= wd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_last_q  <= rsp_last_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_last_o  = rsp_last_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = cyc_q;
  assign wb_dat_o    = wdat_q;
  assign wb_adr_o    = adr_q;
  assign wb_we_o     = we_q;
  assign wb_sel_o    = sel_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = stb_q;

endmodule

// File: tb/tb_wb_master_port.sv
// Scoreboard bench for wb_master_port: stimulus pushes expected responses, a negedge
// monitor pops and compares every rsp_valid_o pulse and logs accepted bus beats.
module tb_wb_master_port;

  localparam int unsigned LEN_W    = 4;
  localparam int unsigned TIMEOUT  = 8;
  localparam int unsigned ADR_STEP = 4;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid, cmd_ready, cmd_we;
  logic [31:0]      cmd_adr, cmd_dat;
  logic [3:0]       cmd_sel;
  logic [LEN_W-1:0] cmd_len;
  logic             rsp_valid, rsp_last, rsp_err, busy;
  logic [31:0]      rsp_dat;
  logic [31:0]      wb_dat_i, wb_dat_o, wb_adr_o;
  logic             wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_stall_i;
  logic [3:0]       wb_sel_o;

  wb_master_port #(
    .LEN_W   (LEN_W),
    .TIMEOUT (TIMEOUT),
    .ADR_STEP(ADR_STEP)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_we_i   (cmd_we),
    .cmd_adr_i  (cmd_adr),
    .cmd_dat_i  (cmd_dat),
    .cmd_sel_i  (cmd_sel),
    .cmd_len_i  (cmd_len),
    .rsp_valid_o(rsp_valid),
    .rsp_dat_o  (rsp_dat),
    .rsp_last_o (rsp_last),
    .rsp_err_o  (rsp_err),
    .busy_o     (busy),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_adr_o   (wb_adr_o),
    .wb_we_o    (wb_we_o),
    .wb_sel_o   (wb_sel_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_ack_i   (wb_ack_i),
    .wb_stall_i (wb_stall_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: lat0 acks on the accepting edge, otherwise one cycle later.
  logic        ack_en, lat0, ack1_q;
  logic [31:0] dat1_q;

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return a ^ 32'hC0DE0000;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack1_q <= 1'b0;
      dat1_q <= '0;
    end else begin
      ack1_q <= wb_cyc_o && wb_stb_o && !wb_stall_i && ack_en && !lat0;
      dat1_q <= slave_data(wb_adr_o);
    end
  end

  assign wb_ack_i = lat0 ? (wb_cyc_o && wb_stb_o && !wb_stall_i && ack_en) : ack1_q;
  assign wb_dat_i = lat0 ? slave_data(wb_adr_o) : dat1_q;

  typedef struct packed {
    logic [31:0] dat;
    logic        last;
    logic        err;
  } rsp_t;

  typedef struct packed {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } beat_t;

  rsp_t        exp_q[$];
  beat_t       beat_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc_cycles = 0;
  int          stb_cycles = 0;
  int          probe_cycles = 0;
  logic [31:0] probe_adr = 32'hFFFF_FFFF;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (wb_cyc_o) cyc_cycles++;
      if (wb_cyc_o && wb_stb_o) stb_cycles++;
      if (wb_cyc_o && wb_stb_o && wb_adr_o == probe_adr) probe_cycles++;
      if (wb_cyc_o && wb_stb_o && !wb_stall_i) begin
        beat_t b;
        b.adr = wb_adr_o;
        b.we  = wb_we_o;
        b.sel = wb_sel_o;
        b.dat = wb_dat_o;
        beat_q.push_back(b);
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got rsp dat %h last %b err %b, required none",
                   rsp_dat, rsp_last, rsp_err);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          check32("rsp_dat", rsp_dat, e.dat);
          check32("rsp_last", {31'b0, rsp_last}, {31'b0, e.last});
          check32("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        end
      end
    end
  end

  task automatic expect_rsp(input logic [31:0] dat, input logic last, input logic err);
    rsp_t e;
    e.dat  = dat;
    e.last = last;
    e.err  = err;
    exp_q.push_back(e);
  endtask

  task automatic start_test();
    beat_q.delete();
    cyc_cycles   = 0;
    stb_cycles   = 0;
    probe_cycles = 0;
  endtask

  // Returns #1 after the edge that accepted the command.
  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [LEN_W-1:0] len);
    bit ok = 1'b0;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    cmd_len   = len;
    cmd_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept: got ready=0 for 40 cycles, required acceptance");
    end
  endtask

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #2;
      if (!wb_cyc_o && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check_int({name, "_done"}, int'(ok), 1);
    if (!ok) exp_q.delete();
  endtask

  task automatic check_beat(input string name, input int idx, input logic [31:0] adr,
                            input logic we, input logic [3:0] sel, input logic [31:0] dat);
    if (idx >= beat_q.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0d beats, required beat %0d", name, beat_q.size(), idx);
    end else begin
      check32({name, "_adr"}, beat_q[idx].adr, adr);
      check32({name, "_we"}, {31'b0, beat_q[idx].we}, {31'b0, we});
      check32({name, "_sel"}, {28'b0, beat_q[idx].sel}, {28'b0, sel});
      if (we) check32({name, "_dat"}, beat_q[idx].dat, dat);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_we     = 1'b0;
    cmd_adr    = '0;
    cmd_dat    = '0;
    cmd_sel    = '0;
    cmd_len    = '0;
    wb_stall_i = 1'b0;
    ack_en     = 1'b1;
    lat0       = 1'b1;

    // Reset state
    #12;
    check32("rst_ready", {31'b0, cmd_ready}, 32'd1);
    check32("rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
    check32("rst_stb", {31'b0, wb_stb_o}, 32'd0);
    check32("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check32("rst_busy", {31'b0, busy}, 32'd0);
    check32("rst_adr", wb_adr_o, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single read, ack one cycle after strobe
    lat0 = 1'b0;
    start_test();
    expect_rsp(32'hDEADBEEF, 1'b1, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 4'hF, 4'd1);
    wait_done("single_read");
    check_int("single_read_stb_cycles", stb_cycles, 1);
    check_int("single_read_cyc_cycles", cyc_cycles, 2);
    check_beat("single_read_b0", 0, 32'h10, 1'b0, 4'hF, 32'h0);

    // Zero-wait read burst
    lat0 = 1'b1;
    start_test();
    expect_rsp(32'hC0DE0100, 1'b0, 1'b0);
    expect_rsp(32'hC0DE0104, 1'b0, 1'b0);
    expect_rsp(32'hC0DE0108, 1'b0, 1'b0);
    expect_rsp(32'hC0DE010C, 1'b1, 1'b0);
    issue(1'b0, 32'h100, 32'h0, 4'hF, 4'd4);
    wait_done("burst");
    check_int("burst_stb_cycles", stb_cycles, 4);
    check_int("burst_cyc_cycles", cyc_cycles, 4);
    check_int("burst_beats", beat_q.size(), 4);
    check_beat("burst_b0", 0, 32'h100, 1'b0, 4'hF, 32'h0);
    check_beat("burst_b1", 1, 32'h104, 1'b0, 4'hF, 32'h0);
    check_beat("burst_b2", 2, 32'h108, 1'b0, 4'hF, 32'h0);
    check_beat("burst_b3", 3, 32'h10C, 1'b0, 4'hF, 32'h0);

    // Same burst with the second beat stalled for three cycles
    start_test();
    probe_adr = 32'h104;
    expect_rsp(32'hC0DE0100, 1'b0, 1'b0);
    expect_rsp(32'hC0DE0104, 1'b0, 1'b0);
    expect_rsp(32'hC0DE0108, 1'b0, 1'b0);
    expect_rsp(32'hC0DE010C, 1'b1, 1'b0);
    issue(1'b0, 32'h100, 32'h0, 4'hF, 4'd4);
    @(posedge clk);
    #1 wb_stall_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 wb_stall_i = 1'b0;
    wait_done("stall");
    check_int("stall_adr104_cycles", probe_cycles, 4);
    check_int("stall_stb_cycles", stb_cycles, 7);
    check_int("stall_beats", beat_q.size(), 4);
    check_beat("stall_b1", 1, 32'h104, 1'b0, 4'hF, 32'h0);
    check_beat("stall_b2", 2, 32'h108, 1'b0, 4'hF, 32'h0);
    probe_adr = 32'hFFFF_FFFF;

    // Single write, length ignored
    start_test();
    expect_rsp(32'h0, 1'b1, 1'b0);
    issue(1'b1, 32'h20, 32'hA5A5A5A5, 4'h3, 4'd7);
    wait_done("write");
    check_int("write_beats", beat_q.size(), 1);
    check_beat("write_b0", 0, 32'h20, 1'b1, 4'h3, 32'hA5A5A5A5);

    // Length 0 behaves as a single beat
    start_test();
    expect_rsp(32'hC0DE0030, 1'b1, 1'b0);
    issue(1'b0, 32'h30, 32'h0, 4'hF, 4'd0);
    wait_done("len0");
    check_int("len0_beats", beat_q.size(), 1);

    // Slave never acks: watchdog abort
    ack_en = 1'b0;
    start_test();
    expect_rsp(32'h0, 1'b1, 1'b1);
    issue(1'b0, 32'h40, 32'h0, 4'hF, 4'd1);
    wait_done("timeout");
    check_int("timeout_cyc_cycles", cyc_cycles, 9);
    check32("timeout_ready", {31'b0, cmd_ready}, 32'd1);
    ack_en = 1'b1;
    start_test();
    expect_rsp(32'h0, 1'b1, 1'b0);
    issue(1'b1, 32'h44, 32'h12345678, 4'hF, 4'd0);
    wait_done("after_timeout");
    check_beat("after_timeout_b0", 0, 32'h44, 1'b1, 4'hF, 32'h12345678);

    // Reset during the second beat of a burst
    start_test();
    expect_rsp(32'hC0DE0100, 1'b0, 1'b0);
    issue(1'b0, 32'h100, 32'h0, 4'hF, 4'd4);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check32("mid_rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
    check32("mid_rst_stb", {31'b0, wb_stb_o}, 32'd0);
    check32("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check32("mid_rst_busy", {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check32("mid_rst_ready", {31'b0, cmd_ready}, 32'd1);
    check_int("mid_rst_pending", exp_q.size(), 0);
    lat0 = 1'b0;
    start_test();
    expect_rsp(32'hC0DE0200, 1'b0, 1'b0);
    expect_rsp(32'hC0DE0204, 1'b1, 1'b0);
    issue(1'b0, 32'h200, 32'h0, 4'hF, 4'd2);
    wait_done("post_rst");
    check_int("post_rst_beats", beat_q.size(), 2);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
